// File: rtl/line_loader.sv
// Byte-stream loader for the instruction line memory: packs bytes MSB first into
// LINE_WIDTH-bit lines and writes them to consecutive addresses from 0.
module line_loader #(
  parameter int LINE_WIDTH = 32,
  parameter int IP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [IP_WIDTH-1:0]   wr_addr,
  output logic [LINE_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [IP_WIDTH:0]     lines_loaded
);

  localparam int BYTES_PER_LINE = LINE_WIDTH / 8;
  localparam int IDX_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [IP_WIDTH-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LINE_WIDTH-1:0] shift_q, shift_d;
  logic [IP_WIDTH:0]     lines_q, lines_d;
  logic                  ovf_q, ovf_d;

  logic accept;
  logic last_byte;
  logic line_is_sentinel;
  logic addr_is_last;

  assign accept           = (state_q == ASSEMBLE) && in_valid;
  assign last_byte        = accept && (idx_q == LAST_IDX);
  assign line_is_sentinel = &shift_q;
  assign addr_is_last     = &addr_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      lines_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      lines_q <= lines_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = ASSEMBLE;
      ASSEMBLE:   if (last_byte) state_d = WRITE;
      WRITE:      state_d = (line_is_sentinel || addr_is_last) ? DONE : ASSEMBLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    lines_d = lines_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          addr_d  = '0;
          idx_d   = '0;
          lines_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ASSEMBLE: begin
        if (accept) begin
          // Shifting left keeps the first byte of the line in the top byte lane.
          shift_d = (shift_q << 8) | LINE_WIDTH'(in_data);
          idx_d   = last_byte ? '0 : idx_q + IDX_W'(1);
        end
      end
      WRITE: begin
        lines_d = lines_q + (IP_WIDTH+1)'(1);
        idx_d   = '0;
        if (line_is_sentinel)  ovf_d = 1'b0;
        else if (addr_is_last) ovf_d = 1'b1;
        else                   addr_d = addr_q + IP_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ASSEMBLE);
    wr_en    = (state_q == WRITE);
    busy     = (state_q == ASSEMBLE) || (state_q == WRITE);
    done     = (state_q == DONE);
  end

  assign wr_addr      = addr_q;
  assign wr_data      = shift_q;
  assign overflow     = ovf_q;
  assign lines_loaded = lines_q;

endmodule

// File: tb/tb_line_loader.sv
// Bench for line_loader: a full-size instance and a 4-line (IP_WIDTH=2) instance,
// checked against a stream-level write model plus literal expectations.
module tb_line_loader;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    int          inst;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_v[2];
  logic       valid_v[2];
  logic [7:0] din_v[2];

  logic        ready0, wren0, busy0, done0, ovf0;
  logic [7:0]  addr0;
  logic [31:0] data0;
  logic [8:0]  ll0;
  logic        ready1, wren1, busy1, done1, ovf1;
  logic [1:0]  addr1;
  logic [31:0] data1;
  logic [2:0]  ll1;

  line_loader #(.LINE_WIDTH(32), .IP_WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start_v[0]), .in_data(din_v[0]),
    .in_valid(valid_v[0]), .in_ready(ready0), .wr_en(wren0), .wr_addr(addr0),
    .wr_data(data0), .busy(busy0), .done(done0), .overflow(ovf0), .lines_loaded(ll0)
  );

  line_loader #(.LINE_WIDTH(32), .IP_WIDTH(2)) dut_s (
    .clk(clk), .n_rst(n_rst), .start(start_v[1]), .in_data(din_v[1]),
    .in_valid(valid_v[1]), .in_ready(ready1), .wr_en(wren1), .wr_addr(addr1),
    .wr_data(data1), .busy(busy1), .done(done1), .overflow(ovf1), .lines_loaded(ll1)
  );

  logic        ready_v[2], wren_v[2], busy_v[2], done_v[2], ovf_v[2];
  logic [7:0]  addr_v[2];
  logic [31:0] data_v[2];
  logic [8:0]  ll_v[2];

  assign ready_v[0] = ready0;  assign ready_v[1] = ready1;
  assign wren_v[0]  = wren0;   assign wren_v[1]  = wren1;
  assign busy_v[0]  = busy0;   assign busy_v[1]  = busy1;
  assign done_v[0]  = done0;   assign done_v[1]  = done1;
  assign ovf_v[0]   = ovf0;    assign ovf_v[1]   = ovf1;
  assign addr_v[0]  = addr0;   assign addr_v[1]  = {6'd0, addr1};
  assign data_v[0]  = data0;   assign data_v[1]  = data1;
  assign ll_v[0]    = ll0;     assign ll_v[1]    = {6'd0, ll1};

  int n_checks = 0;
  int n_fail   = 0;

  wr_t         exp_q[$];
  logic [7:0]  got_addr[$];
  logic [31:0] got_data[$];
  int          exp_lines;
  bit          exp_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream-level model: group bytes into 4-byte lines, address them 0,1,2,...
  // and stop at the all-ones line or after the last address.
  task automatic model_load(input int inst, input bytes_t b, input int ipw);
    int nlines = b.size() / 4;
    int maxa   = (1 << ipw) - 1;
    exp_lines = 0;
    exp_ovf   = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      wr_t w;
      w.inst = inst;
      w.addr = 8'(l);
      w.data = {b[4*l], b[4*l+1], b[4*l+2], b[4*l+3]};
      exp_q.push_back(w);
      exp_lines++;
      if (w.data == 32'hFFFF_FFFF) break;
      if (l == maxa) begin
        exp_ovf = 1'b1;
        break;
      end
    end
  endtask

  // Per-cycle compare: every write strobe must match the next modelled write.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (busy_v[k] && done_v[k]) check("busy_and_done", 1, 0);
      if (ready_v[k] && !busy_v[k]) check("ready_without_busy", 1, 0);
      if (wren_v[k]) begin
        if (exp_q.size() == 0 || exp_q[0].inst != k) begin
          check("unexpected_wr_en", {24'd0, addr_v[k], data_v[k]}, 0);
        end else begin
          check("wr_addr", addr_v[k], exp_q[0].addr);
          check("wr_data", data_v[k], exp_q[0].data);
          void'(exp_q.pop_front());
        end
        got_addr.push_back(addr_v[k]);
        got_data.push_back(data_v[k]);
      end
    end
  end

  task automatic do_start(input int inst);
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  // Drives bytes over the handshake; optional valid toggling and a start pulse
  // raised while byte index start_at is pending (with valid low that cycle).
  task automatic send(input int inst, input bytes_t b, input bit toggle, input int start_at);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    bit  pulsed = 1'b0;
    bit  acc;
    while (i < b.size()) begin
      @(negedge clk);
      start_v[inst] = 1'b0;
      if (i == start_at && !pulsed) begin
        start_v[inst] = 1'b1;
        valid_v[inst] = 1'b0;
        din_v[inst]   = 8'hEE;
        pulsed = 1'b1;
      end else begin
        valid_v[inst] = toggle ? ph : 1'b1;
        din_v[inst]   = valid_v[inst] ? b[i] : 8'h5A;
        ph = ~ph;
      end
      acc = valid_v[inst] && ready_v[inst];
      @(posedge clk);
      if (acc) i++;
      if (++guard > 400) begin
        check("send_timeout", i, b.size());
        break;
      end
    end
    @(negedge clk);
    valid_v[inst] = 1'b0;
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst);
    int n = 0;
    while (!done_v[inst] && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done_v[inst], 1);
  endtask

  task automatic check_end(input int inst, input string tag);
    check({tag, "_done"}, done_v[inst], 1);
    check({tag, "_busy"}, busy_v[inst], 0);
    check({tag, "_in_ready"}, ready_v[inst], 0);
    check({tag, "_overflow"}, ovf_v[inst], exp_ovf);
    check({tag, "_lines_loaded"}, ll_v[inst], exp_lines);
    check({tag, "_all_writes_seen"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input int inst, input string tag);
    check({tag, "_in_ready"}, ready_v[inst], 0);
    check({tag, "_wr_en"}, wren_v[inst], 0);
    check({tag, "_busy"}, busy_v[inst], 0);
    check({tag, "_done"}, done_v[inst], 0);
    check({tag, "_overflow"}, ovf_v[inst], 0);
    check({tag, "_lines_loaded"}, ll_v[inst], 0);
    check({tag, "_wr_addr"}, addr_v[inst], 0);
    check({tag, "_wr_data"}, data_v[inst], 0);
  endtask

  initial begin
    bytes_t s;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      valid_v[k] = 1'b0;
      din_v[k]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset_small");
    n_rst = 1'b1;

    // Basic load, valid held high
    s = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    got_addr.delete(); got_data.delete();
    model_load(0, s, 8);
    do_start(0);
    send(0, s, 1'b0, -1);
    wait_done(0);
    check_end(0, "basic");
    check("basic_lit_data0", got_data.size() > 0 ? got_data[0] : 32'hX, 32'h1234_5678);
    check("basic_lit_addr1", got_addr.size() > 1 ? got_addr[1] : 8'hX, 8'd1);
    check("basic_lit_data1", got_data.size() > 1 ? got_data[1] : 32'hX, 32'hFFFF_FFFF);
    check("basic_lit_lines", ll_v[0], 9'd2);

    // Same stream, valid toggling (restarted from DONE)
    got_addr.delete(); got_data.delete();
    model_load(0, s, 8);
    do_start(0);
    send(0, s, 1'b1, -1);
    wait_done(0);
    check_end(0, "toggle");
    check("toggle_lit_data0", got_data.size() > 0 ? got_data[0] : 32'hX, 32'h1234_5678);

    // Small address space fills before any sentinel
    s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
          8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04};
    got_addr.delete(); got_data.delete();
    model_load(1, s, 2);
    do_start(1);
    send(1, s, 1'b0, -1);
    wait_done(1);
    check_end(1, "ovf");
    check("ovf_lit_overflow", ovf_v[1], 1'b1);
    check("ovf_lit_addr3", got_addr.size() > 3 ? got_addr[3] : 8'hX, 8'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_v[1] = 1'b1;
      din_v[1]   = 8'h05;
      #1 check("ovf_fifth_line_in_ready", ready_v[1], 0);
    end
    @(negedge clk);
    valid_v[1] = 1'b0;

    // Restart after overflow clears it
    s = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    got_addr.delete(); got_data.delete();
    model_load(1, s, 2);
    do_start(1);
    send(1, s, 1'b0, -1);
    wait_done(1);
    check_end(1, "restart");
    check("restart_lit_addr0", got_addr.size() > 0 ? got_addr[0] : 8'hX, 8'd0);
    check("restart_lit_data0", got_data.size() > 0 ? got_data[0] : 32'hX, 32'hAABB_CCDD);
    check("restart_lit_lines", ll_v[1], 9'd2);

    // Reset after two bytes of the second line
    s = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_load(0, s, 8);
    do_start(0);
    send(0, s, 1'b0, -1);
    s = '{8'h55, 8'h66};
    send(0, s, 1'b0, -1);
    n_rst = 1'b0;
    @(negedge clk);
    check_zero(0, "midreset");
    check("midreset_queue", exp_q.size(), 0);
    n_rst = 1'b1;
    s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    got_addr.delete(); got_data.delete();
    model_load(0, s, 8);
    do_start(0);
    send(0, s, 1'b0, -1);
    wait_done(0);
    check_end(0, "after_reset");
    check("after_reset_lit_addr0", got_addr.size() > 0 ? got_addr[0] : 8'hX, 8'd0);

    // start pulsed mid-line is ignored
    s = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
          8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    got_addr.delete(); got_data.delete();
    model_load(0, s, 8);
    do_start(0);
    send(0, s, 1'b0, 6);
    wait_done(0);
    check_end(0, "midstart");
    check("midstart_lit_addr1", got_addr.size() > 1 ? got_addr[1] : 8'hX, 8'd1);
    check("midstart_lit_data1", got_data.size() > 1 ? got_data[1] : 32'hX, 32'hB1B2_B3B4);
    check("midstart_lit_lines", ll_v[0], 9'd4);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_loader.md
Name: line_loader

Overview:
- Write-side counterpart of the instruction line memory. Accepts a byte stream over a valid/ready handshake, packs the bytes into LINE_WIDTH-bit instruction lines, and writes them to consecutive line addresses starting at 0.
- Holds the CPU off while loading (busy).
- Stops after writing the all-ones halt sentinel line, or when the address space is exhausted.

Parameters:
- LINE_WIDTH, 32, instruction line width in bits; must be a multiple of 8.
- IP_WIDTH, 8, line address width; the address space is 2**IP_WIDTH lines.
- BYTES_PER_LINE, LINE_WIDTH/8, bytes per line (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  synchronous active-low reset.
- start  input  1  begin a new load at address 0; sampled in IDLE or DONE only.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  one-cycle write strobe to line memory.
- wr_addr  output  IP_WIDTH  line address for the write.
- wr_data  output  LINE_WIDTH  assembled line.
- busy  output  1  load in progress (ASSEMBLE or WRITE); CPU holds while high.
- done  output  1  load finished; held until the next start or reset.
- overflow  output  1  address space filled before the sentinel arrived; valid while done=1.
- lines_loaded  output  IP_WIDTH+1  number of lines written, sentinel included.

Behaviour:
- Reset
  - Synchronous: n_rst low at a rising edge sets the state to IDLE.
  - All outputs go to 0; address, byte index, shift register and counters are cleared.
  - Reset mid-load discards the partial line and never issues wr_en.
- IDLE
  - in_ready=0, busy=0, done=0.
  - start=1 moves to ASSEMBLE next cycle with addr=0, byte index=0, lines_loaded=0, overflow=0.
- ASSEMBLE
  - in_ready=1, busy=1.
  - A byte is accepted when in_valid and in_ready are both high on a clock edge.
  - Bytes are packed MSB first: the first byte goes to bits [LINE_WIDTH-1:LINE_WIDTH-8].
  - in_valid low stalls without losing the index; gaps of any length are allowed.
  - Accepting byte BYTES_PER_LINE moves to WRITE.
- WRITE (exactly one cycle)
  - in_ready=0, busy=1, wr_en=1, wr_addr=addr, wr_data=assembled line.
  - wr_en is asserted the cycle after the last byte handshake (1-cycle latency). lines_loaded increments on this edge.
  - If wr_data is all ones: go to DONE, overflow=0. The sentinel is written so the halt marker is in memory.
  - Else if addr is 2**IP_WIDTH-1: go to DONE, overflow=1.
  - Else: addr increments, byte index clears, return to ASSEMBLE.
- DONE
  - done=1, busy=0, in_ready=0.
  - overflow and lines_loaded hold their values.
  - start=1 restarts exactly as from IDLE (done clears the next cycle).
- start is ignored in ASSEMBLE and WRITE.
- Outside WRITE: wr_en=0. wr_addr and wr_data hold their last values and are don't-care.
- in_data is ignored whenever in_ready=0, whatever the value of in_valid.
- Addresses never wrap: no write occurs beyond 2**IP_WIDTH-1.
- lines_loaded never exceeds 2**IP_WIDTH.

Test Plan:
- Reset, start, then stream 12 34 56 78, FF FF FF FF with in_valid held high:
  - wr_en at addr 0 with 32'h12345678.
  - wr_en at addr 1 with 32'hFFFFFFFF.
  - Then done=1, overflow=0, lines_loaded=2, in_ready=0.
- Same stream with in_valid toggling every other cycle, plus in_valid high during the WRITE cycle: identical writes and data; no byte is lost or duplicated.
- IP_WIDTH=2, four non-sentinel lines 00000001 to 00000004:
  - Writes land at addr 0 to 3.
  - done=1, overflow=1, lines_loaded=4.
  - A fifth line's bytes are not accepted (in_ready=0).
- Reset asserted after 2 bytes of the second line:
  - No wr_en for the partial line; all outputs are 0.
  - After a new start, the first write goes to addr 0.
- After DONE, pulse start and send AA BB CC DD, FF FF FF FF: wr_en at addr 0 with 32'hAABBCCDD, lines_loaded=2, overflow cleared.
- start pulsed mid-ASSEMBLE: ignored; the byte index and address continue unchanged.
